// File: rtl/lynx_flit_pkg.sv
// Lynx flit layout shared by traffic sources and sink decoders: field positions, packing, FSM states.
package lynx_flit_pkg;

  localparam int unsigned FLIT_MAX_W = 256;
  localparam int          ID_W       = 8;

  typedef logic [FLIT_MAX_W-1:0] flit_max_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} tpg_state_e;

  // Field positions, LSB of each field, MSB-first order RETURN..counter
  function automatic int dcw_of(input int width, input int naw, input int vaw);
    return width - 3 * naw - 2 * vaw - ID_W;
  endfunction

  function automatic int id_pos(input int width, input int naw, input int vaw);
    return dcw_of(width, naw, vaw);
  endfunction

  function automatic int vc_pos(input int width, input int naw, input int vaw);
    return id_pos(width, naw, vaw) + ID_W;
  endfunction

  function automatic int dst_pos(input int width, input int naw, input int vaw);
    return vc_pos(width, naw, vaw) + vaw;
  endfunction

  function automatic int src_pos(input int width, input int naw, input int vaw);
    return dst_pos(width, naw, vaw) + naw;
  endfunction

  function automatic int rvc_pos(input int width, input int naw, input int vaw);
    return src_pos(width, naw, vaw) + naw;
  endfunction

  function automatic int ret_pos(input int width, input int naw, input int vaw);
    return rvc_pos(width, naw, vaw) + vaw;
  endfunction

  function automatic flit_max_t put_field(input flit_max_t v, input int w, input int pos);
    flit_max_t m;
    m = (flit_max_t'(1) << w) - flit_max_t'(1);
    return (v & m) << pos;
  endfunction

  function automatic flit_max_t pack_flit(input int width, input int naw, input int vaw,
                                          input flit_max_t ret, input flit_max_t ret_vc,
                                          input flit_max_t src, input flit_max_t dst,
                                          input flit_max_t vc, input flit_max_t id,
                                          input flit_max_t cnt);
    return put_field(ret,    naw,  ret_pos(width, naw, vaw))
         | put_field(ret_vc, vaw,  rvc_pos(width, naw, vaw))
         | put_field(src,    naw,  src_pos(width, naw, vaw))
         | put_field(dst,    naw,  dst_pos(width, naw, vaw))
         | put_field(vc,     vaw,  vc_pos(width, naw, vaw))
         | put_field(id,     ID_W, id_pos(width, naw, vaw))
         | put_field(cnt,    dcw_of(width, naw, vaw), 0);
  endfunction

endpackage

// File: rtl/tpg_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable; exposes current and next state.
module tpg_lfsr #(
  parameter logic [15:0] SEED = 16'hA500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] lfsr_q,
  output logic [15:0] lfsr_next_c
);

  assign lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next_c;
    end
  end

endmodule

// File: rtl/traffic_source.sv
// NoC traffic source: injects lynx-layout flits over valid/ready and raises done after NUM_TESTS+1 flits.
// Define TPG_RANDOM_DST_EN for LFSR-chosen destinations (overrides DST_MODE).
module traffic_source
  import lynx_flit_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N             = 16,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned N_ADDR_WIDTH  = $clog2(N),
  parameter int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter logic [7:0]  ID            = 8'd0,
  parameter int unsigned NODE          = 0,
  parameter int unsigned DST           = 15,
  parameter int unsigned DST_MODE      = 0,
  parameter int unsigned VC            = 0,
  parameter int unsigned RET_VC        = 0,
  parameter int unsigned GAP           = 0,
  parameter int unsigned NUM_TESTS     = 1000,
  localparam int DCW_RAW = dcw_of(int'(WIDTH), int'(N_ADDR_WIDTH), int'(VC_ADDR_WIDTH)),
  localparam int DCW     = (DCW_RAW > 0) ? DCW_RAW : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [DCW-1:0]   sent_count,
  output logic             done
);

  if (DCW_RAW <= 0) begin : g_chk_dcw
    $error("traffic_source: WIDTH leaves no data counter bits");
  end
  if (DCW_RAW < $clog2(NUM_TESTS + 2)) begin : g_chk_cnt
    $error("traffic_source: data counter too narrow for NUM_TESTS+1");
  end

  localparam int unsigned    DW       = (N_ADDR_WIDTH > 0) ? N_ADDR_WIDTH : 1;
  localparam int unsigned    GCW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [DCW-1:0] LAST_CNT = DCW'(NUM_TESTS + 1);

  tpg_state_e     state_q, state_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [DW-1:0]  dst_cur, dst_adv;
  logic [WIDTH-1:0] data_d;
  logic [DCW-1:0] sent_d;
  logic           valid_d, done_d, xfer;

  function automatic logic [WIDTH-1:0] make_flit(input logic [DW-1:0] d, input logic [DCW-1:0] c);
    return WIDTH'(pack_flit(int'(WIDTH), int'(N_ADDR_WIDTH), int'(VC_ADDR_WIDTH),
                            flit_max_t'(NODE), flit_max_t'(RET_VC), flit_max_t'(NODE),
                            flit_max_t'(d), flit_max_t'(VC), flit_max_t'(ID), flit_max_t'(c)));
  endfunction

  assign xfer = (state_q == ST_SEND) && valid_out && ready_in;

`ifdef TPG_RANDOM_DST_EN
  logic [15:0] lfsr_q, lfsr_next_c;

  // Low address bits of the LFSR, folded into 0..N-1 and steered off our own node
  function automatic logic [DW-1:0] rnd_map(input logic [15:0] r);
    int unsigned v;
    v = (32'(r) & ((32'd1 << N_ADDR_WIDTH) - 32'd1)) % N;
    if (v == NODE) v = (NODE + 1) % N;
    return DW'(v);
  endfunction

  tpg_lfsr #(.SEED({8'hA5, ID})) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .step        (xfer),
    .lfsr_q      (lfsr_q),
    .lfsr_next_c (lfsr_next_c)
  );

  assign dst_cur = rnd_map(lfsr_q);
  assign dst_adv = rnd_map(lfsr_next_c);
`else
  localparam logic [DW-1:0] DST_RST = (DST_MODE == 1) ? DW'((NODE + 1) % N) : DW'(DST);

  logic [DW-1:0] dst_q;

  function automatic logic [DW-1:0] rr_next(input logic [DW-1:0] d);
    int unsigned v;
    v = (32'(d) + 32'd1) % N;
    if (v == NODE) v = (v + 1) % N;
    if (N == 1) v = NODE;
    return DW'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q <= DST_RST;
    end else if (xfer) begin
      dst_q <= dst_adv;
    end
  end

  assign dst_cur = dst_q;
  assign dst_adv = (DST_MODE == 1) ? rr_next(dst_q) : DW'(DST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_SEND;
      ST_SEND: begin
        if (xfer) begin
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
          else if (GAP > 0)      state_d = ST_GAP;
          else if (enable)       state_d = ST_SEND;
          else                   state_d = ST_IDLE;
        end
      end
      ST_GAP:  if (gap_q == GAP_LAST) state_d = enable ? ST_SEND : ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; a presented flit is held until accepted
  always_comb begin
    valid_d = valid_out;
    data_d  = data_out;
    done_d  = done;
    sent_d  = sent_count;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          valid_d = 1'b1;
          data_d  = make_flit(dst_cur, cnt_q);
        end
      end
      ST_SEND: begin
        if (xfer) begin
          cnt_d  = cnt_q + DCW'(1);
          sent_d = sent_count + DCW'(1);
          if (cnt_q == LAST_CNT) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            valid_d = 1'b0;
            gap_d   = '0;
          end else if (enable) begin
            data_d = make_flit(dst_adv, cnt_q + DCW'(1));
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GCW'(1);
        if (gap_q == GAP_LAST && enable) begin
          valid_d = 1'b1;
          data_d  = make_flit(dst_cur, cnt_q);
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      sent_count <= '0;
      cnt_q      <= DCW'(1);
      gap_q      <= '0;
    end else begin
      valid_out  <= valid_d;
      data_out   <= data_d;
      done       <= done_d;
      sent_count <= sent_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_traffic_source.sv
// Directed bench for traffic_source: reset, stall, enable drop, reset mid-stall, full stream, GAP, round-robin.
module tb_traffic_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u0: defaults
  logic rst0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0;
  logic [31:0] d0; logic v0, done0; logic [9:0] sc0;
  // u1: GAP=3, non-zero header fields
  logic rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0;
  logic [31:0] d1; logic v1, done1; logic [9:0] sc1;
  // u2: round-robin N=4 NODE=1
  logic rst2 = 1'b1, en2 = 1'b0, rdy2 = 1'b0;
  logic [31:0] d2; logic v2, done2; logic [15:0] sc2;

`ifdef TPG_RANDOM_DST_EN
  localparam logic [31:0] M0 = 32'hFF87_FFFF;
  localparam logic [31:0] M2 = 32'hF9FF_FFFF;
`else
  localparam logic [31:0] M0 = 32'hFFFF_FFFF;
  localparam logic [31:0] M2 = 32'hFFFF_FFFF;
`endif

  traffic_source u0 (
    .clk(clk), .rst(rst0), .enable(en0), .data_out(d0), .valid_out(v0),
    .ready_in(rdy0), .sent_count(sc0), .done(done0)
  );

  traffic_source #(.ID(8'h5A), .NODE(3), .DST(9), .VC(1), .RET_VC(1), .GAP(3), .NUM_TESTS(7)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .data_out(d1), .valid_out(v1),
    .ready_in(rdy1), .sent_count(sc1), .done(done1)
  );

  traffic_source #(.N(4), .NODE(1), .DST_MODE(1), .NUM_TESTS(7)) u2 (
    .clk(clk), .rst(rst2), .enable(en2), .data_out(d2), .valid_out(v2),
    .ready_in(rdy2), .sent_count(sc2), .done(done2)
  );

`ifdef TPG_RANDOM_DST_EN
  logic rst3 = 1'b1, en3 = 1'b0, rdy3 = 1'b0;
  logic [39:0] d3; logic v3, done3; logic [17:0] sc3;
  traffic_source #(.WIDTH(40), .ID(8'h3C), .NODE(5), .NUM_TESTS(2000)) u3 (
    .clk(clk), .rst(rst3), .enable(en3), .data_out(d3), .valid_out(v3),
    .ready_in(rdy3), .sent_count(sc3), .done(done3)
  );
`endif

  function automatic logic [31:0] exp0(input int c);
    return {4'd0, 1'b0, 4'd0, 4'd15, 1'b0, 8'h00, 10'(c)};
  endfunction
  function automatic logic [31:0] exp1(input int c);
    return {4'd3, 1'b1, 4'd3, 4'd9, 1'b1, 8'h5A, 10'(c)};
  endfunction
  function automatic logic [31:0] exp2(input int dst, input int c);
    return {2'd1, 1'b0, 2'd1, 2'(dst), 1'b0, 8'h00, 16'(c)};
  endfunction

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({v0, done0, sc0, d0} !== '0) begin bad++; $display("FAIL reset_u0 got v=%0b done=%0b sc=%0d d=%h want all 0", v0, done0, sc0, d0); end
    total++; if ({v1, done1, sc1, d1} !== '0) begin bad++; $display("FAIL reset_u1 got v=%0b done=%0b sc=%0d d=%h want all 0", v1, done1, sc1, d1); end
    total++; if ({v2, done2, sc2, d2} !== '0) begin bad++; $display("FAIL reset_u2 got v=%0b done=%0b sc=%0d d=%h want all 0", v2, done2, sc2, d2); end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    total++; if ({v0, v1, v2} !== 3'b000) begin bad++; $display("FAIL idle_no_enable got valids=%b want 000", {v0, v1, v2}); end
  endtask

  // Stall 5 cycles with enable dropped: flit 1 held, then completes, no new flit follows
  task automatic test_stall_enable_drop();
    en0 = 1'b1; rdy0 = 1'b0;
    @(negedge clk);
    total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(1) & M0)) begin bad++; $display("FAIL first_flit got v=%0b d=%h want v=1 d=%h", v0, d0, exp0(1)); end
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(1) & M0) || sc0 !== 10'd0) begin bad++; $display("FAIL stall_hold[%0d] got v=%0b d=%h sc=%0d want v=1 d=%h sc=0", i, v0, d0, sc0, exp0(1)); end
    end
    rdy0 = 1'b1;
    @(negedge clk);
    total++; if (v0 !== 1'b0 || sc0 !== 10'd1) begin bad++; $display("FAIL drop_complete got v=%0b sc=%0d want v=0 sc=1", v0, sc0); end
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (v0 !== 1'b0) begin bad++; $display("FAIL no_enable_idle[%0d] got v=%0b want 0", i, v0); end
    end
  endtask

  task automatic test_rst_mid_stall();
    en0 = 1'b1; rdy0 = 1'b0;
    @(negedge clk);
    total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(2) & M0)) begin bad++; $display("FAIL second_flit got v=%0b d=%h want v=1 d=%h", v0, d0, exp0(2)); end
    rst0 = 1'b1;
    @(negedge clk);
    total++; if (v0 !== 1'b0 || sc0 !== 10'd0 || done0 !== 1'b0) begin bad++; $display("FAIL rst_stall got v=%0b sc=%0d done=%0b want 0 0 0", v0, sc0, done0); end
    rst0 = 1'b0;
    @(negedge clk);
    total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(1) & M0)) begin bad++; $display("FAIL restart_cnt got v=%0b d=%h want v=1 d=%h", v0, d0, exp0(1)); end
  endtask

  // Back-to-back stream of all 1001 flits with one 5-cycle stall mid-stream
  task automatic test_back_to_back();
    int b0;
    b0 = bad;
    rdy0 = 1'b1; en0 = 1'b1;
    for (int k = 1; k <= 1001; k++) begin
      total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(k) & M0) || sc0 !== 10'(k - 1)) begin bad++; $display("FAIL stream[%0d] got v=%0b d=%h sc=%0d want v=1 d=%h sc=%0d", k, v0, d0, sc0, exp0(k), k - 1); end
`ifdef TPG_RANDOM_DST_EN
      total++; if (d0[22:19] === 4'd0) begin bad++; $display("FAIL rnd_dst_u0[%0d] got dst=%0d want !=0", k, d0[22:19]); end
`endif
      if (k == 500) begin
        rdy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          total++; if (v0 !== 1'b1 || (d0 & M0) !== (exp0(500) & M0) || sc0 !== 10'd499) begin bad++; $display("FAIL mid_stall[%0d] got v=%0b d=%h sc=%0d want v=1 d=%h sc=499", i, v0, d0, sc0, exp0(500)); end
        end
        rdy0 = 1'b1;
      end
      @(negedge clk);
      if (bad != b0) break;
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (v0 !== 1'b0 || done0 !== 1'b1 || sc0 !== 10'd1001) begin bad++; $display("FAIL stream_done[%0d] got v=%0b done=%0b sc=%0d want v=0 done=1 sc=1001", i, v0, done0, sc0); end
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    logic ev, ed;
    int   es;
    en1 = 1'b1; rdy1 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      ev = ((c - 1) % 4 == 0) && (c <= 29);
      ed = (c >= 30);
      es = ((c + 2) / 4 > 8) ? 8 : (c + 2) / 4;
      total++; if (v1 !== ev || done1 !== ed || sc1 !== 10'(es)) begin bad++; $display("FAIL gap_cycle[%0d] got v=%0b done=%0b sc=%0d want v=%0b done=%0b sc=%0d", c, v1, done1, sc1, ev, ed, es); end
      if (ev) begin
        total++; if ((d1 & M0) !== (exp1((c - 1) / 4 + 1) & M0)) begin bad++; $display("FAIL gap_flit[%0d] got d=%h want %h", c, d1, exp1((c - 1) / 4 + 1)); end
      end
    end
  endtask

  task automatic test_round_robin();
    int tbl [8] = '{2, 3, 0, 2, 3, 0, 2, 3};
    en2 = 1'b1; rdy2 = 1'b1;
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL rr_pre got v=%0b want 0", v2); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++; if (v2 !== 1'b1 || (d2 & M2) !== (exp2(tbl[c - 1], c) & M2)) begin bad++; $display("FAIL rr_flit[%0d] got v=%0b d=%h want v=1 d=%h", c, v2, d2, exp2(tbl[c - 1], c)); end
      total++; if (d2[26:25] === 2'd1) begin bad++; $display("FAIL rr_self[%0d] got dst=%0d want !=1", c, d2[26:25]); end
    end
    @(negedge clk);
    total++; if (v2 !== 1'b0 || done2 !== 1'b1 || sc2 !== 16'd8) begin bad++; $display("FAIL rr_done got v=%0b done=%0b sc=%0d want v=0 done=1 sc=8", v2, done2, sc2); end
  endtask

`ifdef TPG_RANDOM_DST_EN
  task automatic test_random_dst();
    int b0;
    b0 = bad;
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    rst3 = 1'b0; en3 = 1'b1; rdy3 = 1'b1;
    for (int k = 1; k <= 2001; k++) begin
      @(negedge clk);
      total++; if (v3 !== 1'b1 || d3[17:0] !== 18'(k) || d3[30:27] === 4'd5) begin bad++; $display("FAIL rnd_flit[%0d] got v=%0b cnt=%0d dst=%0d want v=1 cnt=%0d dst!=5", k, v3, d3[17:0], d3[30:27], k); end
      if (bad != b0) break;
    end
    @(negedge clk);
    total++; if (done3 !== 1'b1 || v3 !== 1'b0) begin bad++; $display("FAIL rnd_done got done=%0b v=%0b want 1 0", done3, v3); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall_enable_drop();
    test_rst_mid_stall();
    test_back_to_back();
    test_gap();
    test_round_robin();
`ifdef TPG_RANDOM_DST_EN
    test_random_dst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
